// File: rtl/fifo_pkg.sv
// Shared definitions for the byte FIFO and its serial transmit consumer.
// The FIFO geometry constants live here so both sides agree on them.
package fifo_pkg;

    localparam int FIFO_DATA_W = 8;
    localparam int FIFO_DEPTH  = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: tick pulses in the last cycle of every CLKS_PER_BIT-cycle
// window, with the window phase restarted by clear.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops bytes from the FIFO read port and sends each one as an asynchronous
// serial frame: start bit, DATA_W data bits LSB first, STOP_BITS stop bits.
module fifo_serial_tx
    import fifo_pkg::*;
#(
    parameter int DATA_W       = FIFO_DATA_W,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    output logic              fifo_re,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              tx,
    output logic              busy,
    output logic              tx_done,
    output logic [15:0]       bytes_sent
);

    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    tx_state_t         state;
    tx_state_t         state_next;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_next;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  bit_cnt_next;
    logic              tx_next;
    logic              tick;
    logic              baud_clear;

    // The bit timer only runs while a frame is on the line; LOAD leaves it at
    // zero so the start bit gets a full period.
    assign baud_clear = (state == IDLE) || (state == FETCH) || (state == LOAD);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(baud_clear),
        .tick (tick)
    );

    // The read strobe is decided in the IDLE cycle itself so a frame can start
    // the same cycle the FIFO stops being empty; reset suppresses the pop.
    assign fifo_re = (state == IDLE) && en && !fifo_empty && !rst;
    assign busy    = (state != IDLE) || fifo_re;
    assign tx_done = (state == STOP) && tick && (bit_cnt == LAST_STOP);

    always_comb begin
        state_next   = state;
        shift_next   = shift;
        bit_cnt_next = bit_cnt;
        case (state)
            IDLE: begin
                if (fifo_re) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                state_next = LOAD;
            end
            LOAD: begin
                shift_next   = fifo_data;
                bit_cnt_next = '0;
                state_next   = START;
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_next = shift >> 1;
                    if (bit_cnt == LAST_DATA) begin
                        bit_cnt_next = '0;
                        state_next   = STOP;
                    end else begin
                        bit_cnt_next = bit_cnt + BIT_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_cnt == LAST_STOP) begin
                        bit_cnt_next = '0;
                        state_next   = IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // tx is registered from the upcoming state so the line level lines up
        // exactly with the state that owns it.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            tx         <= 1'b1;
            bytes_sent <= '0;
        end else begin
            state   <= state_next;
            shift   <= shift_next;
            bit_cnt <= bit_cnt_next;
            tx      <= tx_next;
            if (tx_done) begin
                bytes_sent <= bytes_sent + 16'd1;
            end
        end
    end

endmodule
